nios_setup_cpu_cpu_debug_ocimem_sequencer: RTL

//  Sysclk-domain controller that turns debug-slave action strobes (take_action_ocimem_a/b,

---
 rtl/nios_setup_cpu_cpu_debug_pkg.sv | 27 ++
 rtl/nios_setup_cpu_cpu_debug_ocimem_sequencer_if.sv | 33 +++
 rtl/nios_setup_cpu_cpu_debug_stall_timer.sv | 31 +++
 rtl/nios_setup_cpu_cpu_debug_ocimem_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/nios_setup_cpu_cpu_debug_pkg.sv
// Shared definitions for the OCI debug-memory sequencer: sequencer states and
// the bit positions of the fields carried in the jdo debug payload.
package nios_setup_cpu_cpu_debug_pkg;

  localparam int unsigned JDO_W       = 38;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PTR_LSB     = 17;
  localparam int unsigned WDATA_LSB   = 3;
  localparam int unsigned RD_FLAG_BIT = 35;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_WR    = 2'd2,
    S_ABORT = 2'd3
  } seq_state_t;

  function automatic logic [DATA_W-1:0] jdo_wdata(input logic [JDO_W-1:0] jdo);
    return jdo[WDATA_LSB +: DATA_W];
  endfunction

  // True when two or more of the three action strobes fire together.
  function automatic logic multi_hot3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/nios_setup_cpu_cpu_debug_ocimem_sequencer_if.sv
// Single-word OCI debug memory port: the sequencer is master, the OCI
// RAM/register file is slave.
interface nios_setup_cpu_cpu_debug_ocimem_sequencer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) ();

  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic          mem_waitrequest;
  logic [DW-1:0] mem_readdata;

  modport master (
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_wdata,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_wdata,
    output mem_waitrequest,
    output mem_readdata
  );

endinterface

// File: rtl/nios_setup_cpu_cpu_debug_stall_timer.sv
// Counts stalled cycles of one memory access; expired marks the stalled cycle
// that is the TIMEOUT-th one, so the access can be abandoned at that edge.
module nios_setup_cpu_cpu_debug_stall_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  always_comb begin
    expired = enable && (count == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/nios_setup_cpu_cpu_debug_ocimem_sequencer.sv
// Turns debug-slave action strobes into single-word OCI memory accesses, keeps
// the auto-incrementing debug pointer and reports completion/faults via MonDReg.
module nios_setup_cpu_cpu_debug_ocimem_sequencer
  import nios_setup_cpu_cpu_debug_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]    jdo,
  nios_setup_cpu_cpu_debug_ocimem_sequencer_if.master mem,
  output logic [DW-1:0]       MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic                busy
);

  seq_state_t    state;
  seq_state_t    state_next;

  logic [AW-1:0] ptr;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mon_d_q;
  logic          error_q;

  logic idle;
  logic in_access;
  logic go_a;
  logic go_b;
  logic go_n;
  logic collide;
  logic stray;
  logic accept;
  logic abort;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[WDATA_LSB-1:0], jdo[JDO_W-1:RD_FLAG_BIT+1]};

  nios_setup_cpu_cpu_debug_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Strobe qualification: only IDLE accepts work, with a > b > no_action priority.
  always_comb begin
    idle      = (state == S_IDLE);
    in_access = (state == S_RD) || (state == S_WR);
    go_a      = idle && take_action_ocimem_a;
    go_b      = idle && take_action_ocimem_b && !take_action_ocimem_a;
    go_n      = idle && take_no_action_ocimem_a && !take_action_ocimem_a
                && !take_action_ocimem_b;
    collide   = idle && multi_hot3(take_action_ocimem_a, take_action_ocimem_b,
                                   take_no_action_ocimem_a);
    stray     = !idle && (take_action_ocimem_a || take_action_ocimem_b
                          || take_no_action_ocimem_a);
    accept    = in_access && !mem.mem_waitrequest;
    abort     = in_access && mem.mem_waitrequest && timer_expired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (go_a) begin
          if (jdo[RD_FLAG_BIT]) begin
            state_next = S_RD;
          end
        end else if (go_b) begin
          state_next = S_WR;
        end else if (go_n) begin
          state_next = S_RD;
        end
      end
      S_RD, S_WR: begin
        if (accept) begin
          state_next = S_IDLE;
        end else if (abort) begin
          state_next = S_ABORT;
        end
      end
      S_ABORT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Requests decode from the registered state, so strobes never reach the bus combinationally.
  always_comb begin
    mem.mem_read  = (state == S_RD);
    mem.mem_write = (state == S_WR);
    mem.mem_addr  = ptr;
    mem.mem_wdata = wdata_q;
    monitor_ready = idle;
    busy          = !idle;
    monitor_error = error_q;
    MonDReg       = mon_d_q;
    timer_clear   = !in_access;
    timer_en      = in_access && mem.mem_waitrequest;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= '0;
      wdata_q <= '0;
      mon_d_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (go_a) begin
        ptr <= jdo[PTR_LSB +: AW];
      end else if (accept) begin
        ptr <= ptr + AW'(1);
      end

      if (go_b) begin
        wdata_q <= jdo_wdata(jdo);
        mon_d_q <= jdo_wdata(jdo);
      end else if (accept && (state == S_RD)) begin
        mon_d_q <= mem.mem_readdata;
      end

      // A dropped strobe in the same cycle as an accepted ocimem_a still leaves the error set.
      if (collide || stray || abort) begin
        error_q <= 1'b1;
      end else if (go_a) begin
        error_q <= 1'b0;
      end
    end
  end

endmodule
